// File: rtl/operand2_shifter.sv
// Operand-2 shift unit for the execute stage: LSL/LSR/ASR/ROR/RRX/IMM_ROT with
// ARM-style carry-out, behind a valid/ready pipeline of depth 1 or 2.
module operand2_shifter #(
  parameter int DATA_W  = 32,
  parameter int AMT_W   = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_err
);

  localparam int LOG_W = $clog2(DATA_W);
  // Low amount bits needed after range decode: shift index and the rot4 field.
  localparam int LO_W  = (LOG_W > 4) ? LOG_W : 4;
  localparam int CMP_W = AMT_W + 8;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_RRX = 3'b100;
  localparam logic [2:0] MODE_IMM = 3'b101;

  typedef struct packed {
    logic              err;
    logic              carry;
    logic [DATA_W-1:0] data;
  } res_t;

  function automatic res_t shift_op(
    input logic [2:0]        mode,
    input logic [DATA_W-1:0] a,
    input logic [LO_W-1:0]   n_lo,
    input logic              cin,
    input logic              amt_z,
    input logic              amt_lt,
    input logic              amt_eq
  );
    logic [2*DATA_W-1:0] wide;
    logic [LOG_W-1:0]    sh;
    logic [LOG_W-1:0]    sh_imm;
    logic [DATA_W-1:0]   imm_ext;
    res_t                r;

    sh      = n_lo[LOG_W-1:0];
    sh_imm  = LOG_W'({n_lo[3:0], 1'b0});
    imm_ext = DATA_W'(a[7:0]);
    wide    = '0;
    r.err   = 1'b0;
    r.carry = cin;
    r.data  = a;

    case (mode)
      MODE_LSL: begin
        if (amt_z) begin
          r.data  = a;
          r.carry = cin;
        end else if (amt_lt) begin
          // Bit W of the widened result is the last bit shifted out.
          wide    = {{DATA_W{1'b0}}, a} << sh;
          r.data  = wide[DATA_W-1:0];
          r.carry = wide[DATA_W];
        end else if (amt_eq) begin
          r.data  = '0;
          r.carry = a[0];
        end else begin
          r.data  = '0;
          r.carry = 1'b0;
        end
      end

      MODE_LSR: begin
        if (amt_z) begin
          r.data  = a;
          r.carry = cin;
        end else if (amt_lt) begin
          wide    = {a, {DATA_W{1'b0}}} >> sh;
          r.data  = wide[2*DATA_W-1:DATA_W];
          r.carry = wide[DATA_W-1];
        end else if (amt_eq) begin
          r.data  = '0;
          r.carry = a[DATA_W-1];
        end else begin
          r.data  = '0;
          r.carry = 1'b0;
        end
      end

      MODE_ASR: begin
        if (amt_z) begin
          r.data  = a;
          r.carry = cin;
        end else if (amt_lt) begin
          wide    = {a, {DATA_W{1'b0}}};
          wide    = $signed(wide) >>> sh;
          r.data  = wide[2*DATA_W-1:DATA_W];
          r.carry = wide[DATA_W-1];
        end else begin
          r.data  = {DATA_W{a[DATA_W-1]}};
          r.carry = a[DATA_W-1];
        end
      end

      MODE_ROR: begin
        if (amt_z) begin
          r.data  = a;
          r.carry = cin;
        end else begin
          // A multiple of W rotates to a itself, and carry = a[W-1] falls out.
          wide    = {a, a} >> sh;
          r.data  = wide[DATA_W-1:0];
          r.carry = r.data[DATA_W-1];
        end
      end

      MODE_RRX: begin
        r.data  = {cin, a[DATA_W-1:1]};
        r.carry = a[0];
      end

      MODE_IMM: begin
        wide    = {imm_ext, imm_ext} >> sh_imm;
        r.data  = wide[DATA_W-1:0];
        r.carry = (n_lo[3:0] == 4'd0) ? cin : r.data[DATA_W-1];
      end

      default: begin
        r.data  = '0;
        r.carry = cin;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Range decode uses the full amount, never a truncated copy.
  logic amt_zero;
  logic amt_lt_w;
  logic amt_eq_w;

  assign amt_zero = (in_amt == '0);
  assign amt_lt_w = (CMP_W'(in_amt) <  CMP_W'(DATA_W));
  assign amt_eq_w = (CMP_W'(in_amt) == CMP_W'(DATA_W));

  logic ld_out;
  logic take;
  res_t comb_res;

  assign ld_out = !out_valid || out_ready;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign in_ready = ld_out;
      assign take     = in_valid && ld_out;
      assign comb_res = shift_op(in_mode, in_data, in_amt[LO_W-1:0], in_carry,
                                 amt_zero, amt_lt_w, amt_eq_w);
    end else begin : g_lat2
      logic              s1_valid;
      logic [2:0]        s1_mode;
      logic [DATA_W-1:0] s1_data;
      logic [LO_W-1:0]   s1_amt;
      logic              s1_carry;
      logic              s1_zero;
      logic              s1_lt;
      logic              s1_eq;
      logic              s1_ld;

      assign s1_ld    = !s1_valid || ld_out;
      assign in_ready = s1_ld;
      assign take     = s1_valid && ld_out;
      assign comb_res = shift_op(s1_mode, s1_data, s1_amt, s1_carry,
                                 s1_zero, s1_lt, s1_eq);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_mode  <= '0;
          s1_data  <= '0;
          s1_amt   <= '0;
          s1_carry <= 1'b0;
          s1_zero  <= 1'b0;
          s1_lt    <= 1'b0;
          s1_eq    <= 1'b0;
        end else if (s1_ld) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_mode  <= in_mode;
            s1_data  <= in_data;
            s1_amt   <= in_amt[LO_W-1:0];
            s1_carry <= in_carry;
            s1_zero  <= amt_zero;
            s1_lt    <= amt_lt_w;
            s1_eq    <= amt_eq_w;
          end
        end
      end
    end
  endgenerate

  // Output payload only changes on a real load, so it holds under a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (ld_out) begin
      out_valid <= take;
      if (take) begin
        out_data  <= comb_res.data;
        out_carry <= comb_res.carry;
        out_err   <= comb_res.err;
      end
    end
  end

endmodule

// File: tb/tb_operand2_shifter.sv
// Scoreboard bench for operand2_shifter: directed cases, back-pressure,
// mid-flight reset and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_operand2_shifter;
  localparam int W   = 32;
  localparam int AW  = 8;
  localparam int LAT = 2;

  typedef struct packed {
    logic         err;
    logic         c;
    logic [W-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_mode = '0;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_carry = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_err;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  operand2_shifter #(.DATA_W(W), .AMT_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .in_amt(in_amt), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_err(out_err)
  );

  // Reference: rotations as repeated single-bit steps, shifts as plain operators.
  function automatic exp_t model(input logic [2:0] mode, input logic [W-1:0] a,
                                 input logic [AW-1:0] n, input logic cin);
    exp_t r;
    int   m;
    int   ni;
    ni = int'(n);
    r.err = 1'b0; r.d = a; r.c = cin;
    case (mode)
      3'd0: if (ni != 0) begin
        if (ni < W) begin r.d = a << ni; r.c = a[W-ni]; end
        else if (ni == W) begin r.d = '0; r.c = a[0]; end
        else begin r.d = '0; r.c = 1'b0; end
      end
      3'd1: if (ni != 0) begin
        if (ni < W) begin r.d = a >> ni; r.c = a[ni-1]; end
        else if (ni == W) begin r.d = '0; r.c = a[W-1]; end
        else begin r.d = '0; r.c = 1'b0; end
      end
      3'd2: if (ni != 0) begin
        if (ni < W) begin r.d = W'($signed(a) >>> ni); r.c = a[ni-1]; end
        else begin r.d = {W{a[W-1]}}; r.c = a[W-1]; end
      end
      3'd3: if (ni != 0) begin
        m = ni % W;
        for (int k = 0; k < m; k++) r.d = {r.d[0], r.d[W-1:1]};
        r.c = r.d[W-1];
      end
      3'd4: begin r.d = {cin, a[W-1:1]}; r.c = a[0]; end
      3'd5: begin
        r.d = a & W'(255);
        m = (2 * int'(n[3:0])) % W;
        for (int k = 0; k < m; k++) r.d = {r.d[0], r.d[W-1:1]};
        r.c = (n[3:0] == 4'd0) ? cin : r.d[W-1];
      end
      default: begin r.d = '0; r.c = cin; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Drives one request (called at posedge+1) and books its expectation when accepted.
  task automatic send(input logic [2:0] m, input logic [W-1:0] a, input logic [AW-1:0] n,
                      input logic ci, input exp_t e);
    int waited;
    bit done;
    waited = 0; done = 0;
    in_valid = 1'b1; in_mode = m; in_data = a; in_amt = n; in_carry = ci;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin sb.push_back(e); done = 1; end
      @(posedge clk); #1;
      waited++;
      if (!done && waited > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, want acceptance", waited);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_amt();
    case ($urandom_range(0, 6))
      0: return AW'(0);
      1: return AW'(1);
      2: return AW'(W - 1);
      3: return AW'(W);
      4: return AW'(W + 1);
      default: return AW'($urandom_range(0, 255));
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t g;
      exp_t e;
      g = {out_err, out_carry, out_data};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got data=%h c=%b err=%b, want no output", out_data, out_carry, out_err);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL out_check: got data=%h c=%b err=%b, want data=%h c=%b err=%b",
                   g.d, g.c, g.err, e.d, e.c, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t         bp_exp[4];
    logic [W-1:0] bp_a[4];
    int           idx;
    int           ones;
    int           cycles;
    bit           acc;
    logic [2:0]   rm;
    logic [W-1:0] ra;
    logic [AW-1:0] rn;
    logic         rc;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed cases with hand-derived expectations.
    out_ready = 1'b1;
    send(3'd5, 32'h0000_00FF, 8'd4,  1'b0, '{1'b0, 1'b1, 32'hFF00_0000});
    send(3'd5, 32'h0000_00FF, 8'd0,  1'b1, '{1'b0, 1'b1, 32'h0000_00FF});
    send(3'd0, 32'h8000_0001, 8'd1,  1'b0, '{1'b0, 1'b1, 32'h0000_0002});
    send(3'd0, 32'h8000_0001, 8'd32, 1'b0, '{1'b0, 1'b1, 32'h0000_0000});
    send(3'd0, 32'h8000_0001, 8'd33, 1'b0, '{1'b0, 1'b0, 32'h0000_0000});
    send(3'd0, 32'h8000_0001, 8'd0,  1'b0, '{1'b0, 1'b0, 32'h8000_0001});
    send(3'd2, 32'h8000_0000, 8'd40, 1'b0, '{1'b0, 1'b1, 32'hFFFF_FFFF});
    send(3'd3, 32'h0000_0003, 8'd33, 1'b0, '{1'b0, 1'b1, 32'h8000_0001});
    send(3'd4, 32'h0000_0001, 8'd0,  1'b1, '{1'b0, 1'b1, 32'h8000_0000});
    send(3'd1, 32'h8000_0000, 8'd32, 1'b0, '{1'b0, 1'b1, 32'h0000_0000});
    send(3'd6, 32'h0000_1234, 8'd5,  1'b1, '{1'b1, 1'b1, 32'h0000_0000});
    send(3'd0, 32'h0000_0001, 8'd4,  1'b0, '{1'b0, 1'b0, 32'h0000_0010});
    repeat (4) @(posedge clk); #1;

    // Back-pressure: four back-to-back offers against a stalled consumer.
    for (int k = 0; k < 4; k++) begin
      bp_a[k]   = $urandom;
      bp_exp[k] = model(3'd1, bp_a[k], AW'(k + 1), 1'b0);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (idx < 4) begin
        in_valid = 1'b1; in_mode = 3'd1; in_data = bp_a[idx]; in_amt = AW'(idx + 1); in_carry = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (cyc >= 3) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(bp_exp[0].d));
        chk("stall_carry", 64'(out_carry), 64'(bp_exp[0].c));
      end
      if (in_valid && in_ready) begin sb.push_back(bp_exp[idx]); idx++; end
      @(posedge clk); #1;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    ones = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (idx < 4) begin
        in_valid = 1'b1; in_mode = 3'd1; in_data = bp_a[idx]; in_amt = AW'(idx + 1); in_carry = 1'b0;
      end else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) ones++;
      if (in_valid && in_ready) begin sb.push_back(bp_exp[idx]); idx++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_burst_rate", 64'(ones), 64'd4);
    chk("bp_all_accepted", 64'(idx), 64'd4);
    repeat (3) @(posedge clk); #1;

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send(3'd0, 32'h1234_5678, 8'd3, 1'b0, model(3'd0, 32'h1234_5678, 8'd3, 1'b0));
    send(3'd3, 32'hCAFE_F00D, 8'd7, 1'b1, model(3'd3, 32'hCAFE_F00D, 8'd7, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("reset_kills_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_stale_out", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(3'd2, 32'h8000_0010, 8'd4, 1'b0, model(3'd2, 32'h8000_0010, 8'd4, 1'b0));
    cycles = 0;
    while (!out_valid && cycles < 10) begin @(posedge clk); #1; cycles++; end
    chk("post_reset_latency", 64'(cycles), 64'(LAT - 1));
    repeat (3) @(posedge clk); #1;

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        rm = 3'($urandom_range(0, 7));
        ra = $urandom;
        rn = pick_amt();
        rc = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_mode = rm; in_data = ra; in_amt = rn; in_carry = rc;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(model(in_mode, in_data, in_amt, in_carry));
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycles = 0;
    while (sb.size() != 0 && cycles < 50) begin @(posedge clk); #1; cycles++; end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
